// File: rtl/ruta_datos_divisor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ruta_datos_divisor_if
// Description : Bus bundle between the divider control FSM (master) and the
//               divider datapath (slave).
//               master drives: Est (one-hot state), dividendo, divisor
//               slave drives : divisorNoCero, Cont16NoCero, cociente,
//                              residuo, error_div0, listo
// Revision    : 1.0 - initial release
// ============================================================================
interface ruta_datos_divisor_if #(
    parameter int ANCHO = 16
);
    logic [7:0]       Est;
    logic [ANCHO-1:0] dividendo;
    logic [ANCHO-1:0] divisor;
    logic             divisorNoCero;
    logic             Cont16NoCero;
    logic [ANCHO-1:0] cociente;
    logic [ANCHO-1:0] residuo;
    logic             error_div0;
    logic             listo;

    modport master (
        output Est, dividendo, divisor,
        input  divisorNoCero, Cont16NoCero, cociente, residuo, error_div0, listo
    );

    modport slave (
        input  Est, dividendo, divisor,
        output divisorNoCero, Cont16NoCero, cociente, residuo, error_div0, listo
    );
endinterface
`default_nettype wire

// File: rtl/ruta_datos_divisor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ruta_datos_divisor
// Description : Restoring shift/subtract divider datapath. Sequenced by an
//               external control FSM through the one-hot state vector Est.
// Ports       : reloj  - clock, datapath updates on rising edge
//               reset  - asynchronous active-low reset
//               bus    - slave side of ruta_datos_divisor_if
//                        (Est, operands in; status flags and results out)
// Revision    : 1.0 - initial release
// ============================================================================
module ruta_datos_divisor #(
    parameter int ANCHO = 16
) (
    input  wire logic            reloj,
    input  wire logic            reset,
    ruta_datos_divisor_if.slave  bus
);

    localparam int                c_CONT_W    = $clog2(ANCHO) + 1;
    localparam logic [c_CONT_W-1:0] c_CONT_INIT = c_CONT_W'(ANCHO);

    // One-hot state encodings of the external control FSM
    localparam logic [7:0] c_ST_IDLE  = 8'b0000_0001;
    localparam logic [7:0] c_ST_CHK   = 8'b0000_0010;
    localparam logic [7:0] c_ST_LOAD  = 8'b0000_0100;
    localparam logic [7:0] c_ST_SHIFT = 8'b0000_1000;
    localparam logic [7:0] c_ST_SUB   = 8'b0001_0000;
    localparam logic [7:0] c_ST_LOOP  = 8'b0010_0000;
    localparam logic [7:0] c_ST_DONE  = 8'b0100_0000;
    localparam logic [7:0] c_ST_WAIT  = 8'b1000_0000;

    logic [ANCHO-1:0]    den_q,  den_d;   // divisor register D
    logic [ANCHO-1:0]    num_q,  num_d;   // dividend / quotient register Q
    logic [ANCHO:0]      rem_q,  rem_d;   // partial remainder R (one extra bit)
    logic [c_CONT_W-1:0] cont_q, cont_d;  // iterations remaining
    logic [ANCHO-1:0]    coc_q,  coc_d;
    logic [ANCHO-1:0]    res_q,  res_d;
    logic                err_q,  err_d;

    logic [ANCHO:0]      w_den_ext;
    logic [ANCHO:0]      w_diff;
    logic                w_ge;

    assign w_den_ext = {1'b0, den_q};
    assign w_diff    = rem_q - w_den_ext;
    assign w_ge      = (rem_q >= w_den_ext);

    always_comb begin
        den_d  = den_q;
        num_d  = num_q;
        rem_d  = rem_q;
        cont_d = cont_q;
        coc_d  = coc_q;
        res_d  = res_q;
        err_d  = err_q;

        // Any vector that is not exactly one of these codes (zero or
        // several bits set) falls to default and every register holds.
        case (bus.Est)
            c_ST_IDLE: begin
                den_d = bus.divisor;
                num_d = bus.dividendo;
            end
            c_ST_CHK: begin
                if (den_q == '0) begin
                    coc_d = '1;
                    res_d = num_q;
                    err_d = 1'b1;
                end
            end
            c_ST_LOAD: begin
                rem_d  = '0;
                cont_d = c_CONT_INIT;
                err_d  = 1'b0;
            end
            c_ST_SHIFT: begin
                // {R,Q} << 1 with zero fill into Q[0]
                rem_d = {rem_q[ANCHO-1:0], num_q[ANCHO-1]};
                num_d = {num_q[ANCHO-2:0], 1'b0};
            end
            c_ST_SUB: begin
                if (w_ge) begin
                    rem_d = w_diff;
                    num_d = {num_q[ANCHO-1:1], 1'b1};
                end
                // Saturate rather than wrap if the FSM ever lingers here
                if (cont_q != '0) begin
                    cont_d = cont_q - 1'b1;
                end
            end
            c_ST_LOOP: begin
            end
            c_ST_DONE: begin
                coc_d = num_q;
                res_d = rem_q[ANCHO-1:0];
                err_d = 1'b0;
            end
            c_ST_WAIT: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            den_q  <= '0;
            num_q  <= '0;
            rem_q  <= '0;
            cont_q <= '0;
            coc_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            den_q  <= den_d;
            num_q  <= num_d;
            rem_q  <= rem_d;
            cont_q <= cont_d;
            coc_q  <= coc_d;
            res_q  <= res_d;
            err_q  <= err_d;
        end
    end

    assign bus.divisorNoCero = |den_q;
    assign bus.Cont16NoCero  = |cont_q;
    assign bus.cociente      = coc_q;
    assign bus.residuo       = res_q;
    assign bus.error_div0    = err_q;
    assign bus.listo         = bus.Est[7];

endmodule
`default_nettype wire

// File: tb/tb_ruta_datos_divisor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ruta_datos_divisor
// Description : Self-checking bench for ruta_datos_divisor. Plays the role of
//               the control FSM (Est changes on the falling edge) and checks
//               results against hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ruta_datos_divisor;

    localparam int ANCHO = 16;

    logic reloj;
    logic reset;

    ruta_datos_divisor_if #(.ANCHO(ANCHO)) bus ();

    ruta_datos_divisor #(.ANCHO(ANCHO)) dut (
        .reloj (reloj),
        .reset (reset),
        .bus   (bus)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    int n_chk  = 0;
    int n_miss = 0;
    int n_edges = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] coc;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge
    task automatic tick();
        @(posedge reloj);
        n_edges++;
        @(negedge reloj);
    endtask

    // Sequence one division as the control FSM would. abort_iter pulses reset
    // during state 4 of that iteration; glitch_iter drives a two-hot Est for
    // three edges after state 4 of that iteration.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input int abort_iter, input int glitch_iter,
                           output int edges, output logic nz1, output logic aborted);
        int  it;
        bit  done;
        edges   = 0;
        nz1     = 1'b0;
        aborted = 1'b0;
        bus.dividendo = a;
        bus.divisor   = b;
        bus.Est       = 8'h01;
        tick();
        n_edges = 0;
        bus.Est = 8'h02;
        #1 nz1 = bus.divisorNoCero;
        tick();
        if (!nz1) begin
            bus.Est = 8'h80;
        end else begin
            bus.Est = 8'h04;
            tick();
            it   = 0;
            done = 1'b0;
            while (!done && it < 40) begin
                it++;
                bus.Est = 8'h08;
                tick();
                bus.Est = 8'h10;
                if (it == abort_iter) begin
                    #2 reset = 1'b0;
                    #1;
                    check("abort_cociente",   32'(bus.cociente),      32'd0);
                    check("abort_residuo",    32'(bus.residuo),       32'd0);
                    check("abort_error_div0", 32'(bus.error_div0),    32'd0);
                    check("abort_divNoCero",  32'(bus.divisorNoCero), 32'd0);
                    check("abort_contNoCero", 32'(bus.Cont16NoCero),  32'd0);
                    @(posedge reloj);
                    @(negedge reloj);
                    reset   = 1'b1;
                    bus.Est = 8'h01;
                    aborted = 1'b1;
                    edges   = n_edges;
                    return;
                end
                tick();
                if (it == glitch_iter) begin
                    bus.Est = 8'b0001_1000;
                    repeat (3) tick();
                end
                bus.Est = 8'h20;
                tick();
                if (!bus.Cont16NoCero) done = 1'b1;
            end
            check("loop_terminates", 32'(done), 32'd1);
            bus.Est = 8'h40;
            tick();
            bus.Est = 8'h80;
        end
        #1 edges = n_edges;
    endtask

    initial begin
        int   edges;
        logic nz1;
        logic ab;

        vt[0] = '{a: 16'd100,   b: 16'd7,     coc: 16'd14,    res: 16'd2,  err: 1'b0};
        vt[1] = '{a: 16'hFFFF,  b: 16'd1,     coc: 16'hFFFF,  res: 16'd0,  err: 1'b0};
        vt[2] = '{a: 16'd5,     b: 16'd0,     coc: 16'hFFFF,  res: 16'd5,  err: 1'b1};
        vt[3] = '{a: 16'd3,     b: 16'd10,    coc: 16'd0,     res: 16'd3,  err: 1'b0};
        vt[4] = '{a: 16'd5,     b: 16'd0,     coc: 16'hFFFF,  res: 16'd5,  err: 1'b1};
        vt[5] = '{a: 16'd9,     b: 16'd3,     coc: 16'd3,     res: 16'd0,  err: 1'b0};
        vt[6] = '{a: 16'd1000,  b: 16'd3,     coc: 16'd333,   res: 16'd1,  err: 1'b0};
        vt[7] = '{a: 16'd0,     b: 16'd5,     coc: 16'd0,     res: 16'd0,  err: 1'b0};
        vt[8] = '{a: 16'hFFFF,  b: 16'hFFFF,  coc: 16'd1,     res: 16'd0,  err: 1'b0};
        vt[9] = '{a: 16'd12345, b: 16'd256,   coc: 16'd48,    res: 16'd57, err: 1'b0};

        reset         = 1'b0;
        bus.Est       = 8'h01;
        bus.dividendo = 16'd0;
        bus.divisor   = 16'd0;
        #3;
        check("rst_cociente",   32'(bus.cociente),      32'd0);
        check("rst_residuo",    32'(bus.residuo),       32'd0);
        check("rst_error_div0", 32'(bus.error_div0),    32'd0);
        check("rst_divNoCero",  32'(bus.divisorNoCero), 32'd0);
        check("rst_contNoCero", 32'(bus.Cont16NoCero),  32'd0);
        check("rst_listo",      32'(bus.listo),         32'd0);
        @(negedge reloj);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_div(vt[i].a, vt[i].b, 0, 0, edges, nz1, ab);
            check($sformatf("v%0d_cociente", i),   32'(bus.cociente),   32'(vt[i].coc));
            check($sformatf("v%0d_residuo", i),    32'(bus.residuo),    32'(vt[i].res));
            check($sformatf("v%0d_error_div0", i), 32'(bus.error_div0), 32'(vt[i].err));
            check($sformatf("v%0d_listo", i),      32'(bus.listo),      32'd1);
            check($sformatf("v%0d_divNoCero", i),  32'(nz1),            32'(vt[i].b != 16'd0));
            check($sformatf("v%0d_latency", i),    32'(edges),          (vt[i].b == 16'd0) ? 32'd1 : 32'd51);
            bus.Est = 8'h01;
        end

        // Forced subtract step with the counter already exhausted must not wrap
        bus.Est = 8'h10;
        tick();
        check("cont_saturates", 32'(bus.Cont16NoCero), 32'd0);
        bus.Est = 8'h01;

        // Leave an error flag and all-ones quotient so the reset clear is visible
        run_div(16'd5, 16'd0, 0, 0, edges, nz1, ab);
        check("pre_abort_error", 32'(bus.error_div0), 32'd1);
        run_div(16'd1000, 16'd3, 8, 0, edges, nz1, ab);
        check("abort_taken", 32'(ab), 32'd1);
        run_div(16'd1000, 16'd3, 0, 0, edges, nz1, ab);
        check("rerun_cociente", 32'(bus.cociente), 32'd333);
        check("rerun_residuo",  32'(bus.residuo),  32'd1);
        check("rerun_error",    32'(bus.error_div0), 32'd0);
        bus.Est = 8'h01;

        // Two-hot Est mid-run must freeze the datapath for three edges
        run_div(16'd50000, 16'd7, 0, 5, edges, nz1, ab);
        check("glitch_cociente", 32'(bus.cociente), 32'd7142);
        check("glitch_residuo",  32'(bus.residuo),  32'd6);
        check("glitch_latency",  32'(edges),        32'd54);
        bus.Est = 8'h01;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ruta_datos_divisor.md
RUTA_DATOS_DIVISOR -- requirements
Module: ruta_datos_divisor

Interface
REQ-001 Parameter ANCHO, default 16, is the operand, quotient and remainder width in bits.
REQ-002 reloj  in  1  clock; all datapath registers SHALL update on the rising edge (the control FSM updates on the falling edge).
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Est  in  8  one-hot state vector from the control FSM; bit n = state n (0 idle, 1 divisor check, 2 load, 3 shift, 4 subtract, 5 loop check, 6 done, 7 wait).
REQ-005 dividendo  in  ANCHO  dividend operand.
REQ-006 divisor  in  ANCHO  divisor operand.
REQ-007 divisorNoCero  out  1  high when the captured divisor is non-zero.
REQ-008 Cont16NoCero  out  1  high while iteration count remaining is non-zero.
REQ-009 cociente  out  ANCHO  registered quotient result.
REQ-010 residuo  out  ANCHO  registered remainder result.
REQ-011 error_div0  out  1  registered divide-by-zero flag.
REQ-012 listo  out  1  result valid indication.

Function
REQ-013 Internal registers SHALL be: D (ANCHO), Q (ANCHO), R (ANCHO+1), cont ($clog2(ANCHO)+1 bits), plus the output registers.
REQ-014 Est==8'b00000001: D <= divisor, Q <= dividendo every rising edge (operands track inputs while idle); other registers hold.
REQ-015 Est bit 1: hold D, Q; if D==0 then cociente <= all-ones, residuo <= Q, error_div0 <= 1; else outputs hold.
REQ-016 Est bit 2: R <= 0, cont <= ANCHO, error_div0 <= 0; D, Q hold.
REQ-017 Est bit 3: {R,Q} <= {R,Q} shifted left by 1, zero fill into Q[0]; R MSB receives previous R[ANCHO-1].
REQ-018 Est bit 4: if R >= {0,D} then R <= R - {0,D}, Q[0] <= 1, else R, Q hold; cont <= cont - 1 in the same edge.
REQ-019 Est bit 5: all registers hold (FSM samples Cont16NoCero on the following falling edge).
REQ-020 Est bit 6: cociente <= Q, residuo <= R[ANCHO-1:0], error_div0 <= 0.
REQ-021 Est bit 7: all registers hold.
REQ-022 divisorNoCero SHALL be combinational |D; Cont16NoCero SHALL be combinational |cont.
REQ-023 listo SHALL be combinational Est[7].
REQ-024 Est not exactly one-hot (zero or multiple bits): all registers hold, no arithmetic performed.
REQ-025 cont decrement at 0 SHALL not occur (FSM leaves loop); if forced, cont SHALL saturate at 0.
REQ-026 Latency: 3*ANCHO+3 rising edges from first edge in state 1 to results in state 7 (51 for ANCHO=16); divide-by-zero path reaches state 7 after 1 edge in state 1.
REQ-027 Subtraction SHALL use ANCHO+1 bits; no overflow possible, R[ANCHO] is 0 after every subtract step.

Reset
REQ-028 reset low SHALL immediately clear D, Q, R, cont, cociente, residuo, error_div0 to 0, hence divisorNoCero=0, Cont16NoCero=0.
REQ-029 reset asserted mid-division SHALL abort the operation; after release the datapath SHALL accept new operands in state 0 with no residue of the aborted run.

Verification
REQ-030 dividendo=100, divisor=7, FSM sequence go -> cociente=14, residuo=2, error_div0=0, listo=1 in state 7 after 51 edges.
REQ-031 dividendo=16'hFFFF, divisor=1 -> cociente=16'hFFFF, residuo=0, error_div0=0.
REQ-032 dividendo=5, divisor=0 -> divisorNoCero=0 in state 1, cociente=16'hFFFF, residuo=5, error_div0=1, listo=1.
REQ-033 dividendo=3, divisor=10 -> cociente=0, residuo=3; then 5/0 then 9/3 back-to-back -> error_div0 set then cleared, cociente=3, residuo=0.
REQ-034 reset pulsed low during state 4 of iteration 8 of 1000/3 -> all outputs 0 asynchronously; rerun 1000/3 -> cociente=333, residuo=1.
REQ-035 Est forced to 8'b00011000 for 3 cycles mid-run -> R, Q, cont unchanged; run resumes and completes correctly.
